// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller that sits beside the ID stage.
// It produces multi-cycle stalls for swap instructions and load-use
// dependencies, and per-stage flushes for taken branches resolved in EX.
//
// Ports:
//   clock, reset       - posedge clock, asynchronous active-high reset
//   swap_ctrl          - swap instruction present in ID
//   branch_ctrl        - taken branch resolved in EX (highest priority)
//   id_rs/id_rt        - ID source registers; id_uses_rt qualifies id_rt
//   ex_rd/ex_mem_read  - EX destination register and load flag
//   perf_clear         - synchronous clear of the event counters
//   stall_ctrl         - hold PC and IF/ID (pc_write_en/ifid_write_en = ~stall)
//   bubble_ctrl        - insert NOP into ID/EX (same as stall_ctrl)
//   flush_ctrl         - per-stage flush, bit 0 is IF/ID
//   hazard_state       - registered FSM state
//   stall_events       - saturating count of stalled cycles
//   flush_events       - saturating count of branch flush cycles
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W        = 4,
  parameter int SWAP_STALL_CYCLES = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_STAGES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    swap_ctrl,
  input  logic                    branch_ctrl,
  input  logic [REG_ADDR_W-1:0]   id_rs,
  input  logic [REG_ADDR_W-1:0]   id_rt,
  input  logic                    id_uses_rt,
  input  logic [REG_ADDR_W-1:0]   ex_rd,
  input  logic                    ex_mem_read,
  input  logic                    perf_clear,
  output logic                    stall_ctrl,
  output logic                    pc_write_en,
  output logic                    ifid_write_en,
  output logic                    bubble_ctrl,
  output logic [FLUSH_STAGES-1:0] flush_ctrl,
  output logic [1:0]              hazard_state,
  output logic [CNT_W-1:0]        stall_events,
  output logic [CNT_W-1:0]        flush_events
);

  localparam int MAX_STALL = (SWAP_STALL_CYCLES > LOAD_STALL_CYCLES) ?
                             SWAP_STALL_CYCLES : LOAD_STALL_CYCLES;
  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWAP    = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_hz;
  logic          stall_raw;
  logic          flush_raw;

  // Register 0 is hardwired zero, so a load to it never creates a dependency.
  assign load_hz = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    if (branch_ctrl) begin
      // Taken branch wipes the younger instructions; any stall is moot.
      flush_raw = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE, RELEASE: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (load_hz) begin
            stall_raw = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LOAD;
              cnt_nxt   = CW'(1);
            end
          end else if (swap_ctrl && (state == IDLE)) begin
            // RELEASE ignores swap_ctrl so the stalled swap can advance.
            stall_raw = 1'b1;
            if (SWAP_STALL_CYCLES > 1) begin
              state_nxt = SWAP;
              cnt_nxt   = CW'(1);
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        LOAD: begin
          stall_raw = 1'b1;
          if (int'(cnt) + 1 == LOAD_STALL_CYCLES) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        SWAP: begin
          if (swap_ctrl) begin
            stall_raw = 1'b1;
            if (int'(cnt) + 1 == SWAP_STALL_CYCLES) begin
              state_nxt = RELEASE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are Mealy but held inactive while reset is asserted.
  assign stall_ctrl    = stall_raw & ~reset;
  assign bubble_ctrl   = stall_ctrl;
  assign pc_write_en   = ~stall_ctrl;
  assign ifid_write_en = ~stall_ctrl;
  assign flush_ctrl    = {FLUSH_STAGES{flush_raw & ~reset}};
  assign hazard_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_events <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (perf_clear) begin
        stall_events <= '0;
        flush_events <= '0;
      end else begin
        if (stall_ctrl && (stall_events != '1)) stall_events <= stall_events + 1'b1;
        if (branch_ctrl && (flush_events != '1)) flush_events <= flush_events + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       swap_ctrl, branch_ctrl, id_uses_rt, ex_mem_read, perf_clear;
  logic [3:0] id_rs, id_rt, ex_rd;

  logic        stall_ctrl, pc_write_en, ifid_write_en, bubble_ctrl;
  logic [1:0]  flush_ctrl, hazard_state;
  logic [15:0] stall_events, flush_events;

  logic        s_stall, s_pcw, s_ifw, s_bub;
  logic [1:0]  s_flush, s_state;
  logic [1:0]  s_stall_ev, s_flush_ev;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hazard_ctrl_unit dut (
    .clock(clock), .reset(reset), .swap_ctrl(swap_ctrl), .branch_ctrl(branch_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .perf_clear(perf_clear),
    .stall_ctrl(stall_ctrl), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .bubble_ctrl(bubble_ctrl), .flush_ctrl(flush_ctrl), .hazard_state(hazard_state),
    .stall_events(stall_events), .flush_events(flush_events)
  );

  hazard_ctrl_unit #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .swap_ctrl(swap_ctrl), .branch_ctrl(branch_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .perf_clear(perf_clear),
    .stall_ctrl(s_stall), .pc_write_en(s_pcw), .ifid_write_en(s_ifw),
    .bubble_ctrl(s_bub), .flush_ctrl(s_flush), .hazard_state(s_state),
    .stall_events(s_stall_ev), .flush_events(s_flush_ev)
  );

  typedef struct {
    logic       sw, br;
    logic [3:0] rs, rt;
    logic       ut;
    logic [3:0] rd;
    logic       mr;
    logic       st;   // expected stall
    logic       fl;   // expected flush (all stages)
    logic [1:0] hs;   // expected registered state this cycle
  } vec_t;

  localparam int NV = 23;
  vec_t tv[NV];

  function automatic vec_t mk(logic sw, logic br, logic [3:0] rs, logic [3:0] rt,
                              logic ut, logic [3:0] rd, logic mr,
                              logic st, logic fl, logic [1:0] hs);
    vec_t v;
    v.sw = sw; v.br = br; v.rs = rs; v.rt = rt; v.ut = ut;
    v.rd = rd; v.mr = mr; v.st = st; v.fl = fl; v.hs = hs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    swap_ctrl = 0; branch_ctrl = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rd = 0; ex_mem_read = 0; perf_clear = 0;
  endtask

  task automatic load_hazard();
    idle_inputs();
    ex_mem_read = 1; ex_rd = 4'd5; id_rs = 4'd5;
  endtask

  initial begin
    int stall_sum, flush_sum;
    //            sw br rs rt ut rd mr  st fl hs
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);  // idle
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0);  // swap held 4 cycles: 1,1,0,1
    tv[2]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
    tv[3]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 3);
    tv[4]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1);  // swap dropped in SWAP
    tv[6]  = mk(0, 0, 5, 0, 0, 5, 1,  1, 0, 0);  // load-use via rs
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0);  // ex_rd=0: no hazard
    tv[8]  = mk(0, 0, 1, 5, 0, 5, 1,  0, 0, 0);  // rt match but unused
    tv[9]  = mk(0, 0, 1, 5, 1, 5, 1,  1, 0, 0);  // rt match and used
    tv[10] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0);  // swap then branch abort
    tv[11] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    tv[13] = mk(1, 0, 7, 0, 0, 7, 1,  1, 0, 0);  // load + swap together
    tv[14] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    tv[15] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
    tv[16] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 3);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    tv[18] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0);  // load hazard in RELEASE
    tv[19] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
    tv[20] = mk(1, 0, 3, 0, 0, 3, 1,  1, 0, 3);
    tv[21] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    tv[22] = mk(0, 1, 3, 0, 0, 3, 1,  0, 1, 0);  // branch beats load

    idle_inputs();
    reset = 1;
    #2;
    chk("reset state", 32'(hazard_state), 0);
    chk("reset stall", 32'(stall_ctrl), 0);
    chk("reset pc_we", 32'(pc_write_en), 1);
    chk("reset flush", 32'(flush_ctrl), 0);
    chk("reset stall_ev", 32'(stall_events), 0);

    @(negedge clock);
    reset = 0;

    stall_sum = 0;
    flush_sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clock);
      swap_ctrl = tv[i].sw; branch_ctrl = tv[i].br; id_rs = tv[i].rs; id_rt = tv[i].rt;
      id_uses_rt = tv[i].ut; ex_rd = tv[i].rd; ex_mem_read = tv[i].mr;
      #1;
      chk($sformatf("v%0d state", i), 32'(hazard_state), 32'(tv[i].hs));
      chk($sformatf("v%0d stall", i), 32'(stall_ctrl), 32'(tv[i].st));
      chk($sformatf("v%0d bubble", i), 32'(bubble_ctrl), 32'(tv[i].st));
      chk($sformatf("v%0d pc_we", i), 32'(pc_write_en), 32'(!tv[i].st));
      chk($sformatf("v%0d ifid_we", i), 32'(ifid_write_en), 32'(!tv[i].st));
      chk($sformatf("v%0d flush", i), 32'(flush_ctrl), tv[i].fl ? 32'h3 : 32'h0);
      chk($sformatf("v%0d stall_ev", i), 32'(stall_events), 32'(stall_sum));
      chk($sformatf("v%0d flush_ev", i), 32'(flush_events), 32'(flush_sum));
      chk($sformatf("v%0d sat_stall_ev", i), 32'(s_stall_ev), 32'((stall_sum > 3) ? 3 : stall_sum));
      stall_sum += int'(tv[i].st);
      flush_sum += int'(tv[i].fl);
    end

    // Saturation: clear, then 5 back-to-back load-use stalls.
    @(negedge clock);
    idle_inputs();
    perf_clear = 1;
    @(negedge clock);
    chk("clear stall_ev", 32'(stall_events), 0);
    chk("clear flush_ev", 32'(flush_events), 0);
    chk("clear sat_stall_ev", 32'(s_stall_ev), 0);
    load_hazard();
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("sat stall%0d", k), 32'(stall_ctrl), 1);
      @(negedge clock);
    end
    chk("sat 5 stall_ev", 32'(stall_events), 5);
    chk("sat 5 sat_stall_ev", 32'(s_stall_ev), 3);
    perf_clear = 1;
    #1 chk("clear+stall stall", 32'(stall_ctrl), 1);
    @(negedge clock);
    chk("clear+stall stall_ev", 32'(stall_events), 0);
    chk("clear+stall sat_stall_ev", 32'(s_stall_ev), 0);

    // Asynchronous reset while in SWAP with cnt=1.
    idle_inputs();
    swap_ctrl = 1;
    @(negedge clock);
    #1 chk("pre-reset state", 32'(hazard_state), 1);
    chk("pre-reset stall_ev", 32'(stall_events), 1);
    reset = 1;
    #1;
    chk("async reset state", 32'(hazard_state), 0);
    chk("async reset stall", 32'(stall_ctrl), 0);
    chk("async reset bubble", 32'(bubble_ctrl), 0);
    chk("async reset pc_we", 32'(pc_write_en), 1);
    chk("async reset ifid_we", 32'(ifid_write_en), 1);
    chk("async reset stall_ev", 32'(stall_events), 0);
    chk("async reset flush_ev", 32'(flush_events), 0);
    @(negedge clock);
    reset = 0;
    #1 chk("post-reset swap stall", 32'(stall_ctrl), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the lab CPU, placed beside the ID stage. It generates multi-cycle stalls for swap instructions and load-use dependencies, and per-stage flushes for taken branches resolved in EX. Stall lengths, flush depth and register-address width are configurable. Saturating stall and flush event counters support performance measurement.

Parameters:
REG_ADDR_W, 4, register address width.
SWAP_STALL_CYCLES, 2, stall cycles per swap instruction; must be >= 1.
LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard; must be >= 1.
FLUSH_STAGES, 2, number of pipeline registers flushed on a taken branch; must be >= 1.
CNT_W, 16, width of the event counters.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
swap_ctrl  in  1  swap instruction present in ID.
branch_ctrl  in  1  taken branch resolved in EX.
id_rs  in  REG_ADDR_W  ID source register 1.
id_rt  in  REG_ADDR_W  ID source register 2.
id_uses_rt  in  1  ID instruction reads id_rt.
ex_rd  in  REG_ADDR_W  EX destination register.
ex_mem_read  in  1  EX instruction is a load.
perf_clear  in  1  synchronous clear of the event counters.
stall_ctrl  out  1  hold the PC and IF/ID registers.
pc_write_en  out  1  equals ~stall_ctrl.
ifid_write_en  out  1  equals ~stall_ctrl.
bubble_ctrl  out  1  insert a NOP into ID/EX; equals stall_ctrl.
flush_ctrl  out  FLUSH_STAGES  per-stage flush; bit 0 is IF/ID.
hazard_state  out  2  current FSM state encoding.
stall_events  out  CNT_W  count of stalled cycles.
flush_events  out  CNT_W  count of flush cycles.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE, the cycle counter cnt to 0, and both event counters to 0.
  - While reset is high, outputs are forced to: stall_ctrl=0, bubble_ctrl=0, flush_ctrl=0, pc_write_en=1, ifid_write_en=1.
- Outputs are Mealy: combinational from state, cnt and the current inputs, so a stall asserts in the same cycle the hazard is presented.
- FSM states: IDLE=0, SWAP=1, LOAD=2, RELEASE=3. cnt is sized to hold max(SWAP_STALL_CYCLES, LOAD_STALL_CYCLES).
- load_hz = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- Priority within a cycle: branch_ctrl > load_hz > swap_ctrl.
- branch_ctrl=1, in any state:
  - Outputs this cycle: flush_ctrl = all ones, stall_ctrl=0.
  - Next cycle: state IDLE, cnt 0. Any stall in progress is aborted.
- IDLE:
  - load_hz: stall this cycle; cnt<=1; next state is LOAD, or IDLE if LOAD_STALL_CYCLES==1.
  - else swap_ctrl: stall this cycle; cnt<=1; next state is SWAP, or RELEASE if SWAP_STALL_CYCLES==1.
  - else: no stall.
- LOAD:
  - Stall this cycle; cnt<=cnt+1.
  - When cnt+1==LOAD_STALL_CYCLES, next state is IDLE with cnt 0.
  - A pending swap_ctrl is then handled from IDLE.
- SWAP:
  - If swap_ctrl==1: stall this cycle; cnt<=cnt+1. When cnt+1==SWAP_STALL_CYCLES, next state is RELEASE with cnt 0.
  - If swap_ctrl==0: no stall; next state IDLE, cnt 0.
- RELEASE:
  - Swap detection is suppressed for one cycle, so the swap instruction advances: no stall; next state IDLE.
  - load_hz is still evaluated here, with the same actions as in IDLE.
- Totals: one swap gives exactly SWAP_STALL_CYCLES stalled cycles followed by one free cycle. One load-use hazard gives exactly LOAD_STALL_CYCLES stalled cycles.
- Event counters:
  - stall_events increments on every cycle with stall_ctrl=1.
  - flush_events increments on every cycle with branch_ctrl=1.
  - Both saturate at all ones.
  - perf_clear takes priority over increment.
- hazard_state reflects the registered state.

Test Plan:
- Reset: assert reset mid-SWAP (cnt=1) -> hazard_state=0, stall_ctrl=0, pc_write_en=1, both counters 0 immediately, without waiting for a clock edge.
- Swap, defaults: hold swap_ctrl high for 4 cycles -> stall_ctrl = 1,1,0,1 (a new swap is detected in cycle 4); stall_events=3.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 -> stall_ctrl=1 and bubble_ctrl=1 for 1 cycle. Repeat with ex_rd=0 -> no stall. Repeat with id_rt=5, id_uses_rt=0 -> no stall.
- Branch abort: branch_ctrl=1 during the first SWAP stall cycle -> flush_ctrl=2'b11, stall_ctrl=0, next hazard_state=0; flush_events=1.
- Simultaneous hazards: load_hz and swap_ctrl together in IDLE -> 1 load stall, then 2 swap stalls, then release; 3 stalled cycles total.
- Saturation: CNT_W=2 with 5 stall cycles -> stall_events=3. Then perf_clear=1 together with a stall -> stall_events=0.
